// File: rtl/demux_dispatch_scheduler.sv
// Round-robin dispatch sequencer for the 1-to-16 PE-lane demux.
// Takes a frame of words on a valid/ready stream and gives each word to the next lane in turn.
// Each issued word leaves as a registered select, data word and one-hot write strobe.
module demux_dispatch_scheduler #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  frame_len_i,
  input  logic [3:0]            lane_last_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  input  logic [15:0]           lane_ready_i,
  output logic [3:0]            demux_sel_o,
  output logic [DATA_WIDTH-1:0] demux_data_o,
  output logic [15:0]           lane_we_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [3:0]            last_q, last_d;
  logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [3:0]            lane_ptr_q, lane_ptr_d;
  logic [3:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           we_q, we_d;
  logic                  xfer;

  // Stream handshake and status outputs. lane_ptr never exceeds last_q, so
  // ready bits of unused lanes are never consulted.
  always_comb begin
    in_ready_o   = (state_q == StRun) && lane_ready_i[lane_ptr_q];
    xfer         = in_valid_i && in_ready_o;
    busy_o       = (state_q == StRun) || (state_q == StDone);
    done_o       = (state_q == StDone);
    demux_sel_o  = sel_q;
    demux_data_o = data_q;
    lane_we_o    = we_q;
  end

  // Next-state logic: frame sequencing, round-robin pointer and output capture.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    last_d     = last_q;
    word_cnt_d = word_cnt_q;
    lane_ptr_d = lane_ptr_q;
    sel_d      = sel_q;
    data_d     = data_q;
    we_d       = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d      = frame_len_i;
          last_d     = lane_last_i;
          word_cnt_d = '0;
          lane_ptr_d = '0;
          state_d    = (frame_len_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (xfer) begin
          word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
          lane_ptr_d = (lane_ptr_q == last_q) ? 4'd0 : lane_ptr_q + 4'd1;
          sel_d      = lane_ptr_q;
          data_d     = in_data_i;
          we_d       = 16'd1 << lane_ptr_q;
          if (word_cnt_q == len_q - LEN_WIDTH'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      last_q     <= '0;
      word_cnt_q <= '0;
      lane_ptr_q <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      we_q       <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      last_q     <= last_d;
      word_cnt_q <= word_cnt_d;
      lane_ptr_q <= lane_ptr_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      we_q       <= we_d;
    end
  end

endmodule
